// File: rtl/sa_pkg.sv
// Shared constants, widths and FSM state type for the systolic-array operand feeder.
package sa_pkg;
  localparam int SA_N       = 8;
  localparam int SA_DW      = 8;
  localparam int STREAM_LEN = 3*SA_N - 2;
  localparam int IDX_W      = $clog2(SA_N);
  localparam int CNT_W      = $clog2(STREAM_LEN);
  localparam int LANE_W     = SA_N*SA_DW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } sa_state_e;
endpackage

// File: rtl/sa_operand_bank.sv
// NxN operand store, one N-wide vector per array lane, with a skewed diagonal read port.
module sa_operand_bank
  import sa_pkg::*;
#(
  parameter int N  = SA_N,
  parameter int DW = SA_DW,
  parameter int TW = $clog2(3*N-2)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [$clog2(N)-1:0]  wr_idx,
  input  logic [N*DW-1:0]       wr_data,
  input  logic [TW-1:0]         rd_t,
  output logic [N*DW-1:0]       rd_data
);
  localparam int KW = $clog2(N);

  // mem[l][k]: A uses l=row/k=col, B uses l=col/k=row, so one read rule serves both.
  logic [N-1:0][N-1:0][DW-1:0] mem;
  logic                        wr_ok;

  assign wr_ok = wr_en && ({1'b0, wr_idx} < (KW+1)'(N));

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= wr_data;
  end

  for (genvar l = 0; l < N; l++) begin : g_lane
    logic [TW-1:0]        k;
    logic                 in_win;
    logic [N-1:0][DW-1:0] vec;

    assign k      = rd_t - TW'(l);
    assign in_win = (rd_t >= TW'(l)) && (k < TW'(N));
    // Forward a same-cycle write so a run starting straight into STREAM sees it.
    assign vec    = (wr_ok && wr_idx == KW'(l)) ? wr_data : mem[l];
    assign rd_data[l*DW +: DW] = in_win ? vec[k[KW-1:0]] : '0;
  end
endmodule

// File: rtl/sa_operand_feeder.sv
// Feeds skewed A rows / B columns into an NxN output-stationary systolic array.
// Optional SA_FEEDER_ACCUM_EN adds an accumulate input that skips the clear cycle.
module sa_operand_feeder
  import sa_pkg::*;
#(
  parameter int N  = SA_N,
  parameter int DW = SA_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [$clog2(N)-1:0]  wr_idx,
  input  logic [N*DW-1:0]       wr_data,
  input  logic                  start,
`ifdef SA_FEEDER_ACCUM_EN
  input  logic                  accumulate,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [N*DW-1:0]       a_out,
  output logic [N*DW-1:0]       b_out,
  output logic                  sa_en,
  output logic                  sa_clr
);
  localparam int LEN = 3*N - 2;
  localparam int TW  = $clog2(LEN);

  sa_state_e       state;
  logic [TW-1:0]   cnt;
  logic [TW-1:0]   rd_t;
  logic [N*DW-1:0] a_diag, b_diag;
  logic            a_we, b_we, skip_clr;

`ifdef SA_FEEDER_ACCUM_EN
  assign skip_clr = accumulate;
`else
  assign skip_clr = 1'b0;
`endif

  assign a_we = wr_en && (state == IDLE) && !wr_sel;
  assign b_we = wr_en && (state == IDLE) &&  wr_sel;

  // cnt holds the t currently on the outputs; the banks read the one to register next.
  assign rd_t = (state == STREAM) ? cnt + TW'(1) : '0;

  sa_operand_bank #(.N(N), .DW(DW), .TW(TW)) u_bank_a (
    .clk(clk), .wr_en(a_we), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_t(rd_t), .rd_data(a_diag)
  );

  sa_operand_bank #(.N(N), .DW(DW), .TW(TW)) u_bank_b (
    .clk(clk), .wr_en(b_we), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_t(rd_t), .rd_data(b_diag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_out  <= '0;
      b_out  <= '0;
      sa_en  <= 1'b0;
      sa_clr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            sa_en <= 1'b1;
            cnt   <= '0;
            if (skip_clr) begin
              state  <= STREAM;
              sa_clr <= 1'b0;
              a_out  <= a_diag;
              b_out  <= b_diag;
            end else begin
              state  <= CLEAR;
              sa_clr <= 1'b1;
              a_out  <= '0;
              b_out  <= '0;
            end
          end
        end
        CLEAR: begin
          state  <= STREAM;
          cnt    <= '0;
          sa_clr <= 1'b0;
          a_out  <= a_diag;
          b_out  <= b_diag;
        end
        STREAM: begin
          if (cnt == TW'(LEN-1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sa_en <= 1'b0;
            a_out <= '0;
            b_out <= '0;
          end else begin
            cnt   <= cnt + TW'(1);
            a_out <= a_diag;
            b_out <= b_diag;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_operand_feeder.sv
// Directed bench for sa_operand_feeder with a behavioural 8x8 output-stationary array.
module tb_sa_operand_feeder;
  localparam int N  = 8;
  localparam int DW = 8;
  localparam int KW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [KW-1:0]   wr_idx = '0;
  logic [N*DW-1:0] wr_data = '0;
`ifdef SA_FEEDER_ACCUM_EN
  logic            accumulate = 1'b0;
`endif
  logic            busy, done, sa_en, sa_clr;
  logic [N*DW-1:0] a_out, b_out;

  int tests = 0;
  int fails = 0;

  logic [15:0]   acc   [N][N];
  logic [DW-1:0] ar    [N][N];
  logic [DW-1:0] br    [N][N];
  logic [15:0]   exp_c [N][N];

  sa_operand_feeder #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx),
    .wr_data(wr_data), .start(start),
`ifdef SA_FEEDER_ACCUM_EN
    .accumulate(accumulate),
`endif
    .busy(busy), .done(done), .a_out(a_out), .b_out(b_out),
    .sa_en(sa_en), .sa_clr(sa_clr)
  );

  always #5 clk = ~clk;

  // Array model: operands move east/south one PE per enabled cycle, 16-bit wrapping MAC.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (sa_clr) begin
          acc[i][j] <= '0;
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
        end else if (sa_en) begin
          logic [DW-1:0] av, bv;
          av = (j == 0) ? a_out[i*DW +: DW] : ar[i][(j == 0) ? 0 : j-1];
          bv = (i == 0) ? b_out[j*DW +: DW] : br[(i == 0) ? 0 : i-1][j];
          ar[i][j]  <= av;
          br[i][j]  <= bv;
          acc[i][j] <= acc[i][j] + ({8'd0, av} * {8'd0, bv});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] val(input int m, input int r, input int c);
    case (m)
      1:       return (r == c) ? 8'd1 : 8'd0;
      2:       return 8'd1;
      3:       return 8'd255;
      4:       return 8'(r*N + c + 1);
      default: return 8'd0;
    endcase
  endfunction

  function automatic int c_bad();
    int n = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (acc[i][j] !== exp_c[i][j]) n++;
    return n;
  endfunction

  task automatic set_exp(input int m, input logic [15:0] v);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_c[i][j] = (m == 4) ? 16'(val(4, i, j)) : v;
  endtask

  task automatic wr(input logic sel, input int idx, input logic [N*DW-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_idx = KW'(idx); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_ab(input int am, input int bm);
    logic [N*DW-1:0] d;
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++) d[k*DW +: DW] = val(am, r, k);
      wr(1'b0, r, d);
    end
    for (int c = 0; c < N; c++) begin
      for (int k = 0; k < N; k++) d[k*DW +: DW] = val(bm, k, c);
      wr(1'b1, c, d);
    end
  endtask

  // Pulses start; returns the cycle index of done (edge sampling start = 0), -1 on timeout.
  task automatic run(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin lat = c; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests++;
    if ({busy, done, sa_en, sa_clr, a_out, b_out} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b en=%b clr=%b a=%h b=%h want all 0",
               busy, done, sa_en, sa_clr, a_out, b_out);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_product(input string nm, input int am, input int bm,
                              input int em, input logic [15:0] ev);
    int lat, bad;
    load_ab(am, bm);
    run(lat);
    tests++;
    if (lat !== 24) begin
      $display("FAIL %s_latency: got %0d want 24", nm, lat); fails++;
    end
    set_exp(em, ev);
    bad = c_bad();
    tests++;
    if (bad !== 0) begin
      $display("FAIL %s_result: C[0][0]=%0d C[7][7]=%0d, %0d wrong, want %0d/%0d",
               nm, acc[0][0], acc[7][7], bad, exp_c[0][0], exp_c[7][7]);
      fails++;
    end
    tick();
  endtask

  task automatic test_lane_timing();
    int clr_n = 0, clr_at = -1, b7_bad = 0, t, bad;
    logic [DW-1:0] a3_t2 = 8'hxx, a3_t3 = 8'hxx;
    logic done24 = 1'b0, quiet24 = 1'b0;
    load_ab(0, 2);
    wr(1'b0, 3, 64'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      t = c - 2;
      if (sa_clr) begin clr_n++; clr_at = c; end
      if (c >= 2 && c <= 23) begin
        if (t == 2) a3_t2 = a_out[3*DW +: DW];
        if (t == 3) a3_t3 = a_out[3*DW +: DW];
        if ((b_out[7*DW +: DW] != 0) != (t >= 7 && t <= 14)) b7_bad++;
      end
      if (c == 24) begin
        done24  = done;
        quiet24 = (a_out == 0) && (b_out == 0) && !sa_en && !busy;
      end
      if (c < 24) tick();
    end
    tests++;
    if (a3_t2 !== 8'd0) begin $display("FAIL lane_a3_t2: got %0d want 0", a3_t2); fails++; end
    tests++;
    if (a3_t3 !== 8'd5) begin $display("FAIL lane_a3_t3: got %0d want 5", a3_t3); fails++; end
    tests++;
    if (b7_bad !== 0) begin $display("FAIL lane_b7_window: %0d bad cycles want 0", b7_bad); fails++; end
    tests++;
    if (clr_n !== 1 || clr_at !== 1) begin
      $display("FAIL clr_cycle: got %0d cycles at %0d want 1 at 1", clr_n, clr_at); fails++;
    end
    tests++;
    if (!(done24 && quiet24)) begin
      $display("FAIL done_cycle: done=%b quiet=%b want 1/1", done24, quiet24); fails++;
    end
    set_exp(0, 16'd0);
    for (int j = 0; j < N; j++) exp_c[3][j] = 16'd5;
    bad = c_bad();
    tests++;
    if (bad !== 0) begin $display("FAIL lane_result: %0d wrong C want 0", bad); fails++; end
    tick();
  endtask

  task automatic test_start_during_stream();
    int ndone = 0, first = -1, bad;
    load_ab(1, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin ndone++; if (first < 0) first = c; if (first == c) set_exp(0, 16'd1); end
      if (first == c) begin
        bad = c_bad();
        tests++;
        if (bad !== 0) begin $display("FAIL restart_result: %0d wrong C want 0", bad); fails++; end
      end
      start = (c == 10);
      tick();
    end
    start = 1'b0;
    tests++;
    if (ndone !== 1 || first !== 24) begin
      $display("FAIL restart_ignored: got %0d dones first at %0d want 1 at 24", ndone, first);
      fails++;
    end
  endtask

  task automatic test_write_during_busy();
    int lat, bad;
    load_ab(1, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      wr_en = 1'b1; wr_sel = c[0]; wr_idx = KW'(c % N); wr_data = {N{8'hAA}};
      tick();
    end
    wr_en = 1'b0;
    tick();
    run(lat);
    set_exp(4, 16'd0);
    bad = c_bad();
    tests++;
    if (lat !== 24 || bad !== 0) begin
      $display("FAIL busy_write_ignored: lat=%0d wrong=%0d want 24/0", lat, bad); fails++;
    end
    tick();
  endtask

  task automatic test_rst_mid();
    int lat, bad, late = 0;
    load_ab(1, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({busy, done, sa_en, sa_clr, a_out, b_out} !== '0) begin
      $display("FAIL rst_mid_outputs: got busy=%b done=%b en=%b clr=%b want 0",
               busy, done, sa_en, sa_clr);
      fails++;
    end
    for (int c = 0; c < 30; c++) begin
      if (done || busy) late++;
      tick();
    end
    tests++;
    if (late !== 0) begin $display("FAIL rst_mid_no_done: got %0d active cycles want 0", late); fails++; end
    run(lat);
    bad = c_bad();
    tests++;
    if (lat !== 24 || bad !== 0) begin
      $display("FAIL rst_mid_rerun: lat=%0d wrong=%0d want 24/0", lat, bad); fails++;
    end
    tick();
  endtask

  task automatic test_same_edge_write();
    int lat, bad;
    load_ab(1, 2);
    wr_en = 1'b1; wr_sel = 1'b0; wr_idx = '0; wr_data = {N{8'd2}};
    run(lat);
    set_exp(0, 16'd1);
    for (int j = 0; j < N; j++) exp_c[0][j] = 16'd16;
    bad = c_bad();
    tests++;
    if (lat !== 24 || bad !== 0) begin
      $display("FAIL same_edge_write: lat=%0d wrong=%0d C[0][0]=%0d want 24/0/16",
               lat, bad, acc[0][0]);
      fails++;
    end
    tick();
  endtask

`ifdef SA_FEEDER_ACCUM_EN
  task automatic test_accum();
    int lat1, lat2, bad;
    load_ab(1, 1);
    run(lat1);
    tick();
    accumulate = 1'b1;
    run(lat2);
    accumulate = 1'b0;
    set_exp(0, 16'd0);
    for (int i = 0; i < N; i++) exp_c[i][i] = 16'd2;
    bad = c_bad();
    tests++;
    if (lat1 !== 24 || lat2 !== 23) begin
      $display("FAIL accum_latency: got %0d/%0d want 24/23", lat1, lat2); fails++;
    end
    tests++;
    if (bad !== 0) begin $display("FAIL accum_result: %0d wrong C want 0", bad); fails++; end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_product("identity", 1, 4, 4, 16'd0);
    test_product("ones", 2, 2, 0, 16'd8);
    test_product("wrap", 3, 3, 0, 16'd61448);
    test_lane_timing();
    test_start_during_stream();
    test_write_during_busy();
    test_rst_mid();
    test_same_edge_write();
`ifdef SA_FEEDER_ACCUM_EN
    test_accum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sa_operand_feeder.md
Name: sa_operand_feeder

Overview:
- Upstream stage of the 8x8 output-stationary systolic array.
- Holds one NxN A matrix (row-wise) and one NxN B matrix (column-wise) loaded over a simple write port.
- On start, clears the array's accumulators, then streams diagonally skewed A rows (west edge) and B columns (north edge) so that PE(i,j) accumulates C[i][j] = sum_k A[i][k]*B[k][j].
- Drives the array's operand, enable and clear inputs directly.

Parameters:
- N, 8, array dimension (rows = cols = N).
- DW, 8, operand width in bits.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for operand storage.
- wr_sel  in  1  0 = write A row; 1 = write B column.
- wr_idx  in  $clog2(N)  row index (A) or column index (B).
- wr_data  in  N*DW  lane k at [k*DW +: DW]: A[wr_idx][k] or B[k][wr_idx].
- start  in  1  single-cycle request to run one multiply.
- busy  out  1  high from the clear cycle through the last stream cycle.
- done  out  1  one-cycle pulse; array results valid this cycle.
- a_out  out  N*DW  lane i feeds array row i (west edge, A0..A7).
- b_out  out  N*DW  lane j feeds array column j (north edge, B0..B7).
- sa_en  out  1  drives all array enables (en1/en2/en3 tied together).
- sa_clr  out  1  drives the array rst input (accumulator clear).

Behaviour:
- All outputs registered. Reset values: busy=0, done=0, a_out=0, b_out=0, sa_en=0, sa_clr=0, state=IDLE, counter=0. Storage contents are not cleared by rst and are retained.
- FSM: IDLE -> CLEAR -> STREAM -> DONE -> IDLE.
- Writes:
  - Accepted only in IDLE; wr_en outside IDLE is ignored.
  - wr_idx >= N is ignored.
  - A write and start sampled on the same edge: the write commits first and is used by the run.
- start:
  - Honoured only in IDLE; ignored in every other state.
  - When sampled at edge 0, the next cycle is CLEAR.
- CLEAR (cycle 1):
  - sa_en=1, sa_clr=1, a_out=b_out=0, busy=1.
  - Lasts exactly 1 cycle.
- STREAM (cycles 2 .. 3N-1, i.e. 3N-2 cycles, t = 0..3N-3):
  - sa_en=1, sa_clr=0, busy=1.
  - a_out lane i = A[i][t-i] if 0 <= t-i < N, else 0.
  - b_out lane j = B[t-j][j] if 0 <= t-j < N, else 0.
  - Counter t is $clog2(3N-2) bits wide and does not wrap within a run.
- DONE (cycle 3N):
  - done=1, busy=0, sa_en=0, sa_clr=0, a_out=b_out=0.
  - Array C outputs hold final results; the array holds them while sa_en=0.
  - Returns to IDLE next cycle.
- Latency: start sampled to done = 3N cycles (24 for N=8). A new start is accepted from the IDLE cycle after DONE.
- rst mid-operation:
  - Next cycle is IDLE with all outputs at reset values. No done is issued.
  - Array accumulators are left as they were. The next run's CLEAR resets them.
- Arithmetic: none here. The array's 16-bit accumulators wrap modulo 2^16; the feeder does no saturation.

Optional Feature:
- SA_FEEDER_ACCUM_EN: adds input port accumulate (1 bit), sampled with start.
  - If accumulate=1, CLEAR is skipped (IDLE -> STREAM directly) and results add to the prior array contents. Latency is then 3N-1 cycles.
  - If accumulate=0, behaviour is as above.
- Without the macro: the port is absent and every run clears.

Decomposition:
- Shared package sa_pkg:
  - SA_N, SA_DW defaults.
  - STREAM_LEN = 3*SA_N-2.
  - FSM state enum (IDLE, CLEAR, STREAM, DONE).
  - Lane slice helper width constants.
- One sub-module, sa_operand_bank:
  - NxN x DW register storage with write port.
  - Combinational read of the diagonal selected by t, with out-of-window lanes zeroed.
  - Instantiated twice: A with row-major addressing, B with column-major addressing.
- FSM, counter and output registers stay in the top level.

Test Plan:
- Identity A, B = values 1..64 row-major; start -> done exactly 24 cycles after start; array C equals B.
- All-ones A and B -> every C[i][j] = 8.
- All 255 A and B -> every C = 520200 mod 65536 = 61448 (wrap check).
- Lane timing, with A[3][0]=5:
  - a_out lane 3 = 5 in stream cycle t=3 and 0 in t=2.
  - b_out lane 7 nonzero only in t = 7..14.
  - sa_clr high exactly one cycle before the first stream cycle.
- Protocol:
  - start during STREAM ignored, and no second done.
  - wr_en during busy does not alter a subsequent run's result.
  - rst asserted at t=5 -> next cycle all outputs 0, no done; a following start gives a correct full product.
- With SA_FEEDER_ACCUM_EN: two identity x identity runs, the second with accumulate=1 -> diagonal C = 2, off-diagonal 0; done 23 cycles after the second start.
